// File: rtl/dac_packer.sv
// rtl/dac_packer.sv - serial-to-byte packer writing a two-bank pixel memory in checkerboard order
module dac_packer #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int ROW_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              so_valid,
    input  logic              so_data,
    input  logic              pi_end,
    output logic [7:0]        oem_data,
    output logic [ADDR_W-2:0] oem_addr,
    output logic              odd_wr,
    output logic              even_wr,
    output logic              done,
    output logic              overflow
);

    localparam int              RB     = $clog2(ROW_W);
    localparam logic [ADDR_W:0] N_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] N_LAST = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] N_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        RECV = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [ADDR_W:0] n, n_nx;
    logic [2:0]      bit_cnt, bit_nx;
    logic [7:0]      shreg, sh_nx;
    logic [7:0]      wr_data;
    logic            wr, wr_odd, ovf_nx, full;

    assign full   = (n == N_FULL);
    // Row parity xor column parity selects the bank: even parity lands in the odd bank.
    assign wr_odd = ~(n[RB] ^ n[0]);

    always_comb begin
        state_nx = state;
        n_nx     = n;
        bit_nx   = bit_cnt;
        sh_nx    = shreg;
        ovf_nx   = overflow;
        wr       = 1'b0;
        wr_data  = oem_data;
        case (state)
            RECV: begin
                if (so_valid) begin
                    if (full) begin
                        ovf_nx = 1'b1;
                    end else begin
                        sh_nx  = {shreg[6:0], so_data};
                        bit_nx = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            wr      = 1'b1;
                            wr_data = sh_nx;
                        end
                    end
                end
                // A byte completed on this edge takes slot n; otherwise the first zero goes there.
                if (pi_end) begin
                    bit_nx = '0;
                    sh_nx  = '0;
                    if (!wr && !full) begin
                        wr      = 1'b1;
                        wr_data = '0;
                    end
                    state_nx = (full || n == N_LAST) ? DONE : FILL;
                end
            end
            FILL: begin
                wr      = 1'b1;
                wr_data = '0;
                if (n == N_LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
            end
            default: begin
                state_nx = RECV;
            end
        endcase
        if (wr) begin
            n_nx = n + N_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RECV;
            n        <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            oem_data <= '0;
            oem_addr <= '0;
            odd_wr   <= 1'b0;
            even_wr  <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            n        <= n_nx;
            bit_cnt  <= bit_nx;
            shreg    <= sh_nx;
            overflow <= ovf_nx;
            odd_wr   <= wr & wr_odd;
            even_wr  <= wr & ~wr_odd;
            if (wr) begin
                oem_data <= wr_data;
                oem_addr <= n[ADDR_W-1:1];
            end
            done <= done | (state == DONE);
        end
    end

endmodule
